// File: rtl/param_bounce_counter.sv
// ============================================================================
// Module   : param_bounce_counter
// Purpose  : Bounded up/down/bounce counter with hex 7-segment display output.
//            Define SEG_SCAN_EN to multiplex all count nibbles across NDIG digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_bounce_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MIN_VAL  = 0,
    parameter int unsigned MAX_VAL  = 255,
    parameter int unsigned SCAN_DIV = 4,
    localparam int unsigned NDIG    = (WIDTH + 3) / 4
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             bound,
    output logic [7:0]       seg,
    output logic [NDIG-1:0]  an
);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    localparam logic [WIDTH:0]   MIN_X = (WIDTH + 1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             bound_q, bound_d;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   inc_x;
    logic [WIDTH:0]   dec_x;
    logic             eff;

    // One extra bit keeps the +1/-1 results from aliasing back into range.
    assign count_ext = {1'b0, count_q};
    assign load_ext  = {1'b0, load_value};
    assign inc_x     = count_ext + (WIDTH + 1)'(1);
    assign dec_x     = count_ext - (WIDTH + 1)'(1);

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        bound_d = 1'b0;
        eff     = dir_q;
        if (load) begin
            if (load_ext < MIN_X) begin
                count_d = MIN_W;
            end else if (load_ext > MAX_X) begin
                count_d = MAX_W;
            end else begin
                count_d = load_value;
            end
        end else if (en) begin
            case (mode)
                MODE_UP: begin
                    dir_d = 1'b0;
                    if (inc_x > MAX_X) begin
                        count_d = MIN_W;
                        bound_d = 1'b1;
                    end else begin
                        count_d = inc_x[WIDTH-1:0];
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b1;
                    if ((dec_x < MIN_X) || (dec_x > MAX_X)) begin
                        count_d = MAX_W;
                        bound_d = 1'b1;
                    end else begin
                        count_d = dec_x[WIDTH-1:0];
                    end
                end
                MODE_BOUNCE: begin
                    if (count_ext == MAX_X) begin
                        eff = 1'b1;
                    end else if (count_ext == MIN_X) begin
                        eff = 1'b0;
                    end else begin
                        eff = dir_q;
                    end
                    dir_d   = eff;
                    bound_d = (eff != dir_q);
                    count_d = eff ? dec_x[WIDTH-1:0] : inc_x[WIDTH-1:0];
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            count_q <= MIN_W;
            dir_q   <= 1'b0;
            bound_q <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            bound_q <= bound_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign bound = bound_q;

    logic [3:0] nibble;
    logic [6:0] hex7;

`ifdef SEG_SCAN_EN
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [DIV_W-1:0]  div_q;
    logic [IDX_W-1:0]  idx_q;
    logic [4*NDIG-1:0] count_pad;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign count_pad = (4 * NDIG)'(count_q);

    always_comb begin
        nibble = 4'h0;
        an     = '0;
        for (int d = 0; d < int'(NDIG); d++) begin
            an[d] = (idx_q == IDX_W'(d));
            if (idx_q == IDX_W'(d)) begin
                nibble = count_pad[4*d +: 4];
            end
        end
    end
`else
    assign nibble = 4'(count_q);
    assign an     = NDIG'(1);
`endif

    always_comb begin
        case (nibble)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    end

    assign seg = {1'b0, hex7};

endmodule

`default_nettype wire

// File: tb/tb_param_bounce_counter.sv
// ============================================================================
// Module   : tb_param_bounce_counter
// Purpose  : Directed self-checking bench for param_bounce_counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_bounce_counter;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic       load  = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [3:0] lv4   = 4'h0;
    logic [7:0] lv8   = 8'h00;

    logic [3:0] c_a;   logic d_a, b_a;   logic [7:0] s_a;   logic [0:0] an_a;
    logic [3:0] c_b;   logic d_b, b_b;   logic [7:0] s_b;   logic [0:0] an_b;
    logic [7:0] c_c;   logic d_c, b_c;   logic [7:0] s_c;   logic [1:0] an_c;
    logic [7:0] c_d;   logic d_d, b_d;   logic [7:0] s_d;   logic [1:0] an_d;

    int total = 0;
    int bad   = 0;

    always #5 clk_2 = ~clk_2;

    // Full-range 4-bit counter
    param_bounce_counter #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .SCAN_DIV(1)) u_a (
        .clk_2(clk_2), .reset(reset), .en(en), .load(load), .load_value(lv4), .mode(mode),
        .count(c_a), .dir(d_a), .bound(b_a), .seg(s_a), .an(an_a));

    // Narrow range 3..9
    param_bounce_counter #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(9), .SCAN_DIV(1)) u_b (
        .clk_2(clk_2), .reset(reset), .en(en), .load(load), .load_value(lv4), .mode(mode),
        .count(c_b), .dir(d_b), .bound(b_b), .seg(s_b), .an(an_b));

    // 8-bit with MAX 100 for clamping
    param_bounce_counter #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(100), .SCAN_DIV(2)) u_c (
        .clk_2(clk_2), .reset(reset), .en(en), .load(load), .load_value(lv8), .mode(mode),
        .count(c_c), .dir(d_c), .bound(b_c), .seg(s_c), .an(an_c));

    // 8-bit full range, two digits scanned every 2 cycles
    param_bounce_counter #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(255), .SCAN_DIV(2)) u_d (
        .clk_2(clk_2), .reset(reset), .en(en), .load(load), .load_value(lv8), .mode(mode),
        .count(c_d), .dir(d_d), .bound(b_d), .seg(s_d), .an(an_d));

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        mode = 2'b00; load = 1'b1; en = 1'b1; lv4 = 4'd7; lv8 = 8'd7;
        tick();
        total++;
        if (c_a !== 4'd7) begin bad++; $display("FAIL reset_preload count=%0d want=7", c_a); end
        reset = 1'b1;
        tick();
        total++;
        if (c_a !== 4'd0 || d_a !== 1'b0 || b_a !== 1'b0) begin
            bad++; $display("FAIL reset_a count=%0d dir=%0b bound=%0b want 0/0/0", c_a, d_a, b_a);
        end
        total++;
        if (c_b !== 4'd3) begin bad++; $display("FAIL reset_min count=%0d want=3", c_b); end
        total++;
        if (an_d !== 2'b01) begin bad++; $display("FAIL reset_an an=%b want=01", an_d); end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_bounce();
        int exp_c;
        logic exp_d, exp_b;
        do_reset();
        mode = 2'b10;
        total++;
        if (c_a !== 4'd0) begin bad++; $display("FAIL bounce_start count=%0d want=0", c_a); end
        en = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            exp_c = (k <= 15) ? k : ((k <= 30) ? 30 - k : 1);
            exp_d = (k >= 16 && k <= 30);
            exp_b = (k == 16 || k == 31);
            total++;
            if (c_a !== 4'(exp_c) || d_a !== exp_d || b_a !== exp_b) begin
                bad++;
                $display("FAIL bounce step=%0d count=%0d dir=%0b bound=%0b want %0d/%0b/%0b",
                         k, c_a, d_a, b_a, exp_c, exp_d, exp_b);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_up_wrap();
        int exp_c[3] = '{9, 3, 4};
        int exp_b[3] = '{0, 1, 0};
        do_reset();
        mode = 2'b00; load = 1'b1; lv4 = 4'd8;
        tick();
        total++;
        if (c_b !== 4'd8 || b_b !== 1'b0) begin
            bad++; $display("FAIL up_load count=%0d bound=%0b want 8/0", c_b, b_b);
        end
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (c_b !== 4'(exp_c[i]) || b_b !== 1'(exp_b[i]) || d_b !== 1'b0) begin
                bad++;
                $display("FAIL up_wrap i=%0d count=%0d bound=%0b dir=%0b want %0d/%0d/0",
                         i, c_b, b_b, d_b, exp_c[i], exp_b[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        int exp_c[3] = '{3, 9, 8};
        int exp_b[3] = '{0, 1, 0};
        do_reset();
        mode = 2'b01; load = 1'b1; lv4 = 4'd4;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (c_b !== 4'(exp_c[i]) || b_b !== 1'(exp_b[i]) || d_b !== 1'b1) begin
                bad++;
                $display("FAIL down_wrap i=%0d count=%0d bound=%0b dir=%0b want %0d/%0d/1",
                         i, c_b, b_b, d_b, exp_c[i], exp_b[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_clamp();
        do_reset();
        mode = 2'b10; load = 1'b1; lv8 = 8'd200; lv4 = 4'd1;
        tick();
        total++;
        if (c_c !== 8'd100 || d_c !== 1'b0 || b_c !== 1'b0) begin
            bad++; $display("FAIL clamp_hi count=%0d dir=%0b bound=%0b want 100/0/0", c_c, d_c, b_c);
        end
        total++;
        if (c_b !== 4'd3) begin bad++; $display("FAIL clamp_lo count=%0d want=3", c_b); end
        load = 1'b0; en = 1'b1;
        tick();
        total++;
        if (c_c !== 8'd99 || d_c !== 1'b1 || b_c !== 1'b1) begin
            bad++; $display("FAIL clamp_step count=%0d dir=%0b bound=%0b want 99/1/1", c_c, d_c, b_c);
        end
        en = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        mode = 2'b00; load = 1'b1; lv4 = 4'd5;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'b11;
        tick();
        tick();
        total++;
        if (c_a !== 4'd5 || b_a !== 1'b0 || d_a !== 1'b0) begin
            bad++; $display("FAIL hold_mode count=%0d bound=%0b dir=%0b want 5/0/0", c_a, b_a, d_a);
        end
        en = 1'b0; mode = 2'b00;
        tick();
        total++;
        if (c_a !== 4'd5 || b_a !== 1'b0) begin
            bad++; $display("FAIL hold_en0 count=%0d bound=%0b want 5/0", c_a, b_a);
        end
    endtask

    task automatic test_mode_change();
        do_reset();
        mode = 2'b00; load = 1'b1; lv4 = 4'd5;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'b01;
        tick();
        total++;
        if (c_a !== 4'd4 || d_a !== 1'b1) begin
            bad++; $display("FAIL mode_down count=%0d dir=%0b want 4/1", c_a, d_a);
        end
        mode = 2'b10;
        tick();
        total++;
        if (c_a !== 4'd3 || d_a !== 1'b1 || b_a !== 1'b0) begin
            bad++; $display("FAIL mode_bounce count=%0d dir=%0b bound=%0b want 3/1/0", c_a, d_a, b_a);
        end
        mode = 2'b00;
        tick();
        total++;
        if (c_a !== 4'd4 || d_a !== 1'b0) begin
            bad++; $display("FAIL mode_up count=%0d dir=%0b want 4/0", c_a, d_a);
        end
        en = 1'b0;
    endtask

`ifdef SEG_SCAN_EN
    task automatic test_seg();
        logic [1:0] exp_an[4]  = '{2'b10, 2'b10, 2'b01, 2'b01};
        logic [7:0] exp_seg[4] = '{8'h77, 8'h77, 8'h6D, 8'h6D};
        do_reset();
        load = 1'b1; lv8 = 8'hA5;
        tick();
        load = 1'b0;
        total++;
        if (an_d !== 2'b01 || s_d !== 8'h6D) begin
            bad++; $display("FAIL scan_first an=%b seg=%h want 01/6d", an_d, s_d);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (an_d !== exp_an[i] || s_d !== exp_seg[i]) begin
                bad++;
                $display("FAIL scan i=%0d an=%b seg=%h want %b/%h", i, an_d, s_d, exp_an[i], exp_seg[i]);
            end
        end
    endtask
`else
    task automatic test_seg();
        do_reset();
        load = 1'b1; lv8 = 8'hA5; lv4 = 4'hC;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (an_d !== 2'b01 || s_d !== 8'h6D) begin
                bad++; $display("FAIL seg_static i=%0d an=%b seg=%h want 01/6d", i, an_d, s_d);
            end
            total++;
            if (an_a !== 1'b1 || s_a !== 8'h39) begin
                bad++; $display("FAIL seg_c i=%0d an=%b seg=%h want 1/39", i, an_a, s_a);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bounce();
        test_up_wrap();
        test_down_wrap();
        test_clamp();
        test_hold();
        test_mode_change();
        test_seg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
